// File: rtl/onehot4_pkg.sv
// Shared types and helpers for the 4-way one-hot round-robin grant generator.
package onehot4_pkg;

  localparam int NREQ = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  // First set request bit scanning ptr, ptr+1, ... (mod 4); returns ptr when req is empty.
  function automatic logic [1:0] rr_pick(input logic [NREQ-1:0] req, input logic [1:0] ptr);
    logic [1:0] pick;
    logic [1:0] cand;
    pick = ptr;
    // Walk from the farthest candidate back to ptr so the nearest set bit wins.
    for (int i = NREQ - 1; i >= 0; i--) begin
      cand = ptr + i[1:0];
      if (req[cand]) pick = cand;
    end
    return pick;
  endfunction

  // Binary index to one-hot word.
  function automatic logic [NREQ-1:0] idx2oh(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/onehot4_chk.sv
// Exactly-one-of-four detector: y0 = 1 iff popcount(x3..x0) == 1.
// Purely combinational; also used standalone by grant consumers.
module onehot4_chk (
  input  logic x0,
  input  logic x1,
  input  logic x2,
  input  logic x3,
  output logic y0
);

  // Exactly one high: at least one is set and no pair is set together.
  always_comb begin
    y0 = (x0 | x1 | x2 | x3) &
         ~((x0 & x1) | (x0 & x2) | (x0 & x3) |
           (x1 & x2) | (x1 & x3) | (x2 & x3));
  end

endmodule

// File: rtl/onehot4_rr_grant.sv
// Round-robin grant generator for 4 requesters with break-before-make.
// Every grant is followed by exactly one all-zero cycle before the next one.
// Optional macro ONEHOT4_CHK_EN adds a sticky one-hot violation flag (err)
// driven by onehot4_chk on the registered grant; otherwise err is tied low.
module onehot4_rr_grant
  import onehot4_pkg::*;
#(
  parameter int MAX_HOLD = 0,  // max tenure in cycles, 0 = unlimited
  parameter int CNT_W    = 8   // tenure counter width, 2^CNT_W > MAX_HOLD
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic [3:0] done,
  output logic [3:0] gnt,
  output logic       gnt_vld,
  output logic [1:0] gnt_idx,
  output logic       err
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  state_t           state_q, state_d;
  logic [1:0]       ptr_q,   ptr_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [3:0]       gnt_q,   gnt_d;
  logic             vld_q,   vld_d;
  logic [1:0]       idx_q,   idx_d;

  logic [1:0]       pick;
  logic             hold_hit;
  logic             release_now;

  // Tenure limit reached on this cycle (never when the limit is disabled).
  always_comb begin
    hold_hit    = (MAX_HOLD != 0) && (cnt_q == HOLD_LAST);
    release_now = done[idx_q] | ~req[idx_q] | hold_hit;
    pick        = rr_pick(req, ptr_q);
  end

  // Next-state and next-output computation for the arbitration FSM.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    vld_d   = vld_q;
    idx_d   = idx_q;
    case (state_q)
      // The release edge always lands in GAP with gnt = 0, so no grant can start
      // on that edge. The GAP cycle then arbitrates exactly like IDLE, which keeps
      // the zero window at one cycle for a back-to-back requester.
      IDLE, GAP: begin
        if (req != 4'b0000) begin
          state_d = GRANT;
          idx_d   = pick;
          gnt_d   = idx2oh(pick);
          vld_d   = 1'b1;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      GRANT: begin
        if (release_now) begin
          state_d = GAP;
          gnt_d   = 4'b0000;
          vld_d   = 1'b0;
          idx_d   = 2'd0;
          ptr_d   = idx_q + 2'd1;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 4'b0000;
        vld_d   = 1'b0;
        idx_d   = 2'd0;
      end
    endcase
  end

  // FSM state, pointer, tenure counter and registered grant outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= 2'd0;
      cnt_q   <= '0;
      gnt_q   <= 4'b0000;
      vld_q   <= 1'b0;
      idx_q   <= 2'd0;
    end else begin
      // NOTE: non-blocking assignments so all flops update from pre-edge values.
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      vld_q   <= vld_d;
      idx_q   <= idx_d;
    end
  end

  assign gnt     = gnt_q;
  assign gnt_vld = vld_q;
  assign gnt_idx = idx_q;

`ifdef ONEHOT4_CHK_EN
  logic chk_y0;
  logic err_q, err_d;

  onehot4_chk u_chk (
    .x0 (gnt_q[0]),
    .x1 (gnt_q[1]),
    .x2 (gnt_q[2]),
    .x3 (gnt_q[3]),
    .y0 (chk_y0)
  );

  // A valid grant that is not one-hot, or a valid flag out of step with gnt.
  always_comb begin
    err_d = err_q | (vld_q & ~chk_y0) | (vld_q != (|gnt_q));
  end

  // Sticky violation flag, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_onehot4_rr_grant.sv
// Self-checking bench for onehot4_rr_grant: one unlimited-tenure instance and
// one MAX_HOLD=5 instance, a behavioural owner/pointer model compared every
// cycle, and directed checks with literal expectations.
module tb_onehot4_rr_grant;

  logic       clk;
  logic       rst;
  logic [3:0] req,   done;
  logic [3:0] req_h, done_h;
  logic [3:0] gnt,   gnt_h;
  logic       gnt_vld, gnt_vld_h;
  logic [1:0] gnt_idx, gnt_idx_h;
  logic       err,   err_h;

  int total = 0;
  int bad   = 0;
  bit cmp_on = 1'b1;

  // Model state per instance: current owner (-1 none), next scan start,
  // cycles held so far, tenure limit, expected err.
  int m_owner [2] = '{-1, -1};
  int m_ptr   [2] = '{0, 0};
  int m_held  [2] = '{0, 0};
  int m_max   [2] = '{0, 5};
  bit m_err   [2] = '{1'b0, 1'b0};

  onehot4_rr_grant #(.MAX_HOLD(0), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .req(req), .done(done),
    .gnt(gnt), .gnt_vld(gnt_vld), .gnt_idx(gnt_idx), .err(err)
  );

  onehot4_rr_grant #(.MAX_HOLD(5), .CNT_W(8)) dut_h (
    .clk(clk), .rst(rst), .req(req_h), .done(done_h),
    .gnt(gnt_h), .gnt_vld(gnt_vld_h), .gnt_idx(gnt_idx_h), .err(err_h)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock of the model: an owner keeps the resource until it says done,
  // withdraws its request, or has held it for the limit; with no owner the
  // nearest requester from the pointer wins. Release and regrant never share an edge.
  task automatic model_step(input int k, input logic [3:0] r, input logic [3:0] d);
    int o;
    o = m_owner[k];
    if (o >= 0) begin
      if (d[o] || !r[o] || (m_max[k] != 0 && m_held[k] == m_max[k])) begin
        m_ptr[k]   = (o + 1) % 4;
        m_owner[k] = -1;
      end else begin
        m_held[k]++;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (r[(m_ptr[k] + i) % 4]) begin
          m_owner[k] = (m_ptr[k] + i) % 4;
          m_held[k]  = 1;
          break;
        end
      end
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        m_owner[k] = -1;
        m_ptr[k]   = 0;
        m_held[k]  = 0;
        m_err[k]   = 1'b0;
      end
    end else begin
      model_step(0, req, done);
      model_step(1, req_h, done_h);
    end
  end

  task automatic cmp_one(input string nm, input int k, input logic [3:0] g,
                         input logic v, input logic [1:0] ix, input logic e);
    logic [3:0] eg;
    logic [1:0] ei;
    logic       legal;
    eg = 4'b0000;
    ei = 2'd0;
    if (m_owner[k] >= 0) begin
      eg = 4'b0001 << m_owner[k];
      ei = 2'(m_owner[k]);
    end
    legal = (g == 4'h0) || (g == 4'h1) || (g == 4'h2) || (g == 4'h4) || (g == 4'h8);
    check({nm, ".gnt"},     32'(g),  32'(eg));
    check({nm, ".gnt_vld"}, 32'(v),  32'(m_owner[k] >= 0));
    check({nm, ".gnt_idx"}, 32'(ix), 32'(ei));
    check({nm, ".err"},     32'(e),  32'(m_err[k]));
    check({nm, ".legal"},   32'(legal), 32'd1);
  endtask

  always @(negedge clk) begin
    if (cmp_on) begin
      cmp_one("dut",   0, gnt,   gnt_vld,   gnt_idx,   err);
      cmp_one("dut_h", 1, gnt_h, gnt_vld_h, gnt_idx_h, err_h);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  logic [1:0] order [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
  logic [3:0] order_oh [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

  initial begin
    bit seen;
    req = '0; done = '0; req_h = '0; done_h = '0;
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;

    // Reset state
    check("rst.gnt", 32'(gnt), 32'h0);
    check("rst.vld", 32'(gnt_vld), 32'h0);
    check("rst.idx", 32'(gnt_idx), 32'h0);
    check("rst.err", 32'(err), 32'h0);

    // Single request, drop, one-cycle gap, pointer lands on 3, then wraps to 0
    req = 4'b0100;
    cyc(1);
    check("t1.gnt", 32'(gnt), 32'h4);
    check("t1.idx", 32'(gnt_idx), 32'd2);
    check("t1.vld", 32'(gnt_vld), 32'd1);
    req = 4'b1001;
    cyc(1);
    check("t1.gap", 32'(gnt), 32'h0);
    cyc(1);
    check("t1.ptr3.gnt", 32'(gnt), 32'h8);
    check("t1.ptr3.idx", 32'(gnt_idx), 32'd3);
    done = 4'b1000;
    cyc(1);
    done = 4'b0000;
    check("wrap.gap", 32'(gnt), 32'h0);
    cyc(1);
    check("wrap.gnt", 32'(gnt), 32'h1);
    check("wrap.idx", 32'(gnt_idx), 32'd0);
    req = 4'b0000;
    cyc(2);

    // Fairness with all four requesting and done pulsed after each grant
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      seen = 1'b0;
      for (int w = 0; w < 4 && !seen; w++) begin
        cyc(1);
        if (gnt != 4'b0000) seen = 1'b1;
      end
      check("fair.seen", 32'(seen), 32'd1);
      check("fair.idx", 32'(gnt_idx), 32'(order[k]));
      check("fair.gnt", 32'(gnt), 32'(order_oh[k]));
      done = gnt;
      cyc(1);
      done = 4'b0000;
      check("fair.gap", 32'(gnt), 32'h0);
    end
    req = 4'b0000;
    cyc(2);

    // Tenure limit on the MAX_HOLD=5 instance
    req_h = 4'b0001;
    for (int c = 0; c < 5; c++) begin
      cyc(1);
      check("hold.on", 32'(gnt_h), 32'h1);
    end
    cyc(1);
    check("hold.gap", 32'(gnt_h), 32'h0);
    cyc(1);
    check("hold.regrant", 32'(gnt_h), 32'h1);
    req_h = 4'b0000;
    cyc(2);

    // Non-owner done is ignored; async reset mid-grant; rescan from 0
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    req = 4'b0010;
    cyc(1);
    check("own1.gnt", 32'(gnt), 32'h2);
    done = 4'b1000;
    for (int c = 0; c < 3; c++) begin
      cyc(1);
      check("nonown.gnt", 32'(gnt), 32'h2);
    end
    done = 4'b0000;
    #2 rst = 1'b1;
    #1;
    check("arst.gnt", 32'(gnt), 32'h0);
    check("arst.vld", 32'(gnt_vld), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    req = 4'b1111;
    cyc(1);
    check("arst.rescan.gnt", 32'(gnt), 32'h1);
    check("arst.rescan.idx", 32'(gnt_idx), 32'd0);
    req = 4'b0000;
    cyc(2);

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(7) == 0) req[b]   = ~req[b];
        if ($urandom_range(7) == 0) req_h[b] = ~req_h[b];
        done[b]   = ($urandom_range(5) == 0);
        done_h[b] = ($urandom_range(5) == 0);
      end
      cyc(1);
    end
    req = '0; done = '0; req_h = '0; done_h = '0;
    cyc(3);

`ifdef ONEHOT4_CHK_EN
    // Plant a two-hot grant while idle: err must rise next edge and stick
    cmp_on = 1'b0;
    force dut.gnt_q = 4'b0011;
    cyc(1);
    check("chk.err.set", 32'(err), 32'd1);
    release dut.gnt_q;
    cyc(1);
    m_err[0] = 1'b1;
    cmp_on = 1'b1;
    cyc(3);
    check("chk.err.sticky", 32'(err), 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
